clock_ctrl: RTL and testbench
=============================

Name: clock_ctrl

Overview:
- Timekeeping controller for the digital clock.
- Divides the system clock into a 1 s tick and issues single-cycle enable strobes to the seconds, minutes and hours BCD counters, with carry sequencing.
- Runs a button-driven set-time state machine that lets the user step hours and minutes.
- Sits between the board buttons/clock and the counter instances; it holds no time value of its own.

Parameters:
- TICK_DIV, 50000000, clk cycles per 1 s tick (≥2).
- BLINK_DIV, 12500000, clk cycles per half-period of the set-mode blink output (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- btn_mode  in  1  mode button, asynchronous level, debounced externally
- btn_inc  in  1  increment button, asynchronous level, debounced externally
- sec_tens  in  4  current seconds tens (BCD 0-5) from seconds counter
- sec_units  in  4  current seconds units (BCD 0-9)
- min_tens  in  4  current minutes tens (BCD 0-5)
- min_units  in  4  current minutes units (BCD 0-9)
- sec_en  out  1  one-cycle enable to seconds counter
- min_en  out  1  one-cycle enable to minutes counter
- hr_en  out  1  one-cycle enable to hours counter
- sec_clr  out  1  one-cycle synchronous clear to seconds counter
- mode  out  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN
- blink  out  1  display blank/flash control, 0 in RUN
- tick_1hz  out  1  one-cycle pulse, coincident with sec_en

Behaviour:
Reset:
- reset_n low asynchronously forces: state RUN, prescaler 0, blink counter 0, all synchronizer/edge flops 0.
- All outputs are 0; mode reads 0.
- Reset mid-operation discards any pending strobe.
Button path:
- Each button passes through a 2-flop synchronizer, then a rising-edge detector (edge = sync2 & ~prev).
- The resulting strobe is registered. Its first high cycle starts at the 3rd rising clk edge at which the raw button is sampled high.
- Holding a button produces exactly one event. Release produces none.
Prescaler:
- Counts 0..TICK_DIV-1 in RUN only and wraps to 0.
- At the edge where count == TICK_DIV-1, the registered outputs load:
  - sec_en = tick_1hz = 1.
  - min_en = 1 iff {sec_tens,sec_units} == 5,9.
  - hr_en = 1 iff {sec_tens,sec_units} == 5,9 and {min_tens,min_units} == 5,9.
- All strobes are high for exactly one cycle.
- The counter inputs are sampled at the same edge, before the counters advance.
- Strobe period in RUN is exactly TICK_DIV cycles.
FSM (state held in the mode register):
- RUN --mode event--> SET_HR: prescaler held at 0, no tick strobes.
- SET_HR --mode event--> SET_MIN.
- SET_MIN --mode event--> RUN: sec_clr = 1 for one cycle; prescaler restarts from 0, so the first sec_en comes TICK_DIV cycles after sec_clr.
- SET_HR, inc event: hr_en one cycle. No carry; min_en and sec_en stay 0.
- SET_MIN, inc event: min_en one cycle. No carry into hours; hr_en stays 0.
- RUN, inc event: ignored.
- Mode and inc events in the same cycle: mode wins, inc is dropped.
- Encoding 3 is unreachable; if it is ever entered, the next edge goes to RUN.
Blink:
- In SET_HR/SET_MIN, a blink counter counts 0..BLINK_DIV-1 and blink toggles on wrap.
- On any state change, blink counter and blink are cleared to 0.
- In RUN, blink is held at 0.
Arithmetic:
- Prescaler width is $clog2(TICK_DIV); blink counter width is $clog2(BLINK_DIV).
- BCD compares are exact 4-bit equality. Illegal BCD inputs never match 5 or 9 and produce no carry.

Decomposition:
- Package clock_pkg: MODE_RUN=2'd0, MODE_SET_HR=2'd1, MODE_SET_MIN=2'd2; BCD_SEC_TENS_MAX=4'd5, BCD_UNITS_MAX=4'd9.
- Sub-module btn_edge: 2-flop synchronizer plus rising-edge detector, ports clk, reset_n, btn, pulse; instantiated twice.

Test Plan (TICK_DIV=4, BLINK_DIV=2):
- Release reset, hold sec=0,0, min=0,0 for 12 cycles -> sec_en/tick_1hz high on cycles 4, 8 and 12 after reset deassert; min_en and hr_en stay 0; mode=0.
- sec=5,9, min=1,2, wait for tick -> sec_en=1 and min_en=1 in the same cycle, hr_en=0. Repeat with sec=5,9, min=5,9 -> sec_en, min_en and hr_en all 1 in that cycle.
- Press btn_mode once (held 10 cycles) -> mode=1 at the 3rd edge, exactly once; no sec_en for 20 cycles; blink toggles every 2 cycles.
- In SET_HR press btn_inc twice -> two single hr_en pulses, min_en=0. Press mode, then btn_inc once -> mode=2, one min_en pulse, hr_en=0.
- In SET_MIN press mode -> mode=0, sec_clr pulse of 1 cycle, blink=0, next sec_en exactly 4 cycles later. Assert btn_mode and btn_inc together in SET_HR -> mode=2, no hr_en.
- Pull reset_n low mid-RUN two cycles before a tick -> all outputs 0 immediately, no strobe emitted. After release, first sec_en comes 4 cycles later.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared mode encoding and BCD limits for the clock timekeeping controller.
// Pure declarations, no latency.
// No flow control.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_UNITS_MAX    = 4'd9;

    // True when a tens/units pair reads 59; illegal digits never match.
    function automatic logic is_bcd_59(input logic [3:0] tens, input logic [3:0] units);
        return (tens == BCD_SEC_TENS_MAX) && (units == BCD_UNITS_MAX);
    endfunction

endpackage

// File: rtl/clock_ctrl_btn_edge.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge detector.
// Pulse is high for one cycle after the 2nd edge sampling btn high; consumers register it on the 3rd.
// No backpressure: a held button yields one pulse, release yields none.
module btn_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/clock_ctrl.sv
// Timekeeping controller: 1 s prescaler, counter enable strobes with carry, button set-time FSM.
// Strobes are registered, one cycle wide; button events act at the 3rd edge the raw button is high.
// No backpressure: counters must accept every strobe; simultaneous mode/inc drops the inc.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_units,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_units,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink,
    output logic       tick_1hz
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

    logic          mode_evt;
    logic          inc_evt;
    mode_e         state;
    mode_e         state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_nxt;
    logic          blink_nxt;
    logic          sec_en_nxt;
    logic          min_en_nxt;
    logic          hr_en_nxt;
    logic          sec_clr_nxt;
    logic          sec_wrap;
    logic          min_wrap;

    btn_edge u_mode_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_mode),
        .pulse   (mode_evt)
    );

    btn_edge u_inc_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_inc),
        .pulse   (inc_evt)
    );

    // Counter values are sampled before they advance, so 59 means "about to wrap".
    assign sec_wrap = is_bcd_59(sec_tens, sec_units);
    assign min_wrap = is_bcd_59(min_tens, min_units);

    always_comb begin
        state_nxt   = state;
        presc_nxt   = presc;
        bcnt_nxt    = bcnt;
        blink_nxt   = blink;
        sec_en_nxt  = 1'b0;
        min_en_nxt  = 1'b0;
        hr_en_nxt   = 1'b0;
        sec_clr_nxt = 1'b0;

        case (state)
            MODE_RUN: begin
                if (mode_evt) begin
                    state_nxt = MODE_SET_HR;
                    presc_nxt = '0;
                end else if (presc == PRESC_TOP) begin
                    presc_nxt  = '0;
                    sec_en_nxt = 1'b1;
                    min_en_nxt = sec_wrap;
                    hr_en_nxt  = sec_wrap & min_wrap;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            MODE_SET_HR: begin
                presc_nxt = '0;
                if (mode_evt) begin
                    state_nxt = MODE_SET_MIN;
                end else if (inc_evt) begin
                    hr_en_nxt = 1'b1;
                end
            end
            MODE_SET_MIN: begin
                presc_nxt = '0;
                if (mode_evt) begin
                    state_nxt   = MODE_RUN;
                    sec_clr_nxt = 1'b1;
                end else if (inc_evt) begin
                    min_en_nxt = 1'b1;
                end
            end
            default: begin
                presc_nxt = '0;
                state_nxt = MODE_RUN;
            end
        endcase

        // Blink phase restarts on every mode change so the flash always begins visible.
        if ((state_nxt != state) || (state_nxt == MODE_RUN)) begin
            bcnt_nxt  = '0;
            blink_nxt = 1'b0;
        end else if (bcnt == BLINK_TOP) begin
            bcnt_nxt  = '0;
            blink_nxt = ~blink;
        end else begin
            bcnt_nxt = bcnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= MODE_RUN;
            presc   <= '0;
            bcnt    <= '0;
            blink   <= 1'b0;
            sec_en  <= 1'b0;
            min_en  <= 1'b0;
            hr_en   <= 1'b0;
            sec_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            bcnt    <= bcnt_nxt;
            blink   <= blink_nxt;
            sec_en  <= sec_en_nxt;
            min_en  <= min_en_nxt;
            hr_en   <= hr_en_nxt;
            sec_clr <= sec_clr_nxt;
        end
    end

    assign mode     = state;
    assign tick_1hz = sec_en;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl with small dividers.
// Directed sequences, a carry vector table and a randomized run against a reference model.
module tb_clock_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_tens = 4'd0;
    logic [3:0] sec_units = 4'd0;
    logic [3:0] min_tens = 4'd0;
    logic [3:0] min_units = 4'd0;
    logic       sec_en;
    logic       min_en;
    logic       hr_en;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;
    logic       tick_1hz;

    clock_ctrl #(.TICK_DIV(TICK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_tens  (sec_tens),
        .sec_units (sec_units),
        .min_tens  (min_tens),
        .min_units (min_units),
        .sec_en    (sec_en),
        .min_en    (min_en),
        .hr_en     (hr_en),
        .sec_clr   (sec_clr),
        .mode      (mode),
        .blink     (blink),
        .tick_1hz  (tick_1hz)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse counters sampled just after each rising edge.
    int n_sec = 0, n_min = 0, n_hr = 0, n_clr = 0;
    always @(posedge clk) begin
        #1;
        if (sec_en)  n_sec++;
        if (min_en)  n_min++;
        if (hr_en)   n_hr++;
        if (sec_clr) n_clr++;
    end

    task automatic clr_counts();
        n_sec = 0; n_min = 0; n_hr = 0; n_clr = 0;
    endtask

    // Reference model: events from the raw sample history, ticks from elapsed RUN edges.
    bit  mq[$];
    bit  iq[$];
    int  m_mode = 0;
    int  run_edges = 0;
    int  st_edges = 0;
    bit  e_sec = 0, e_min = 0, e_hr = 0, e_clr = 0, e_blink = 0;

    always @(posedge clk or negedge reset_n) begin
        bit mev, iev;
        if (!reset_n) begin
            mq = '{0, 0, 0};
            iq = '{0, 0, 0};
            m_mode = 0; run_edges = 0; st_edges = 0;
            e_sec = 0; e_min = 0; e_hr = 0; e_clr = 0; e_blink = 0;
        end else begin
            mq.push_back(btn_mode);
            iq.push_back(btn_inc);
            mev = mq[1] && !mq[0];
            iev = iq[1] && !iq[0];
            void'(mq.pop_front());
            void'(iq.pop_front());
            e_sec = 0; e_min = 0; e_hr = 0; e_clr = 0;
            if (mev) begin
                e_clr = (m_mode == 2);
                m_mode = (m_mode + 1) % 3;
                run_edges = 0;
                st_edges = 0;
            end else begin
                st_edges++;
                if (m_mode == 0) begin
                    run_edges++;
                    if (run_edges % TICK_DIV == 0) begin
                        e_sec = 1;
                        e_min = (sec_tens == 5) && (sec_units == 9);
                        e_hr  = e_min && (min_tens == 5) && (min_units == 9);
                    end
                end else if (iev) begin
                    if (m_mode == 1) e_hr = 1;
                    else             e_min = 1;
                end
            end
            e_blink = (m_mode != 0) && (((st_edges / BLINK_DIV) % 2) == 1);
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_v;
        exp_v = {e_sec, e_sec, e_min, e_hr, e_clr, 2'(m_mode), e_blink};
        chk("model", {sec_en, tick_1hz, min_en, hr_en, sec_clr, mode, blink}, exp_v);
    end

    task automatic wait_tick();
        bit found = 0;
        for (int k = 0; k < 2 * TICK_DIV; k++) begin
            @(negedge clk);
            if (sec_en) begin
                found = 1;
                break;
            end
        end
        chk("tick_timeout", found, 1);
    endtask

    task automatic pulse_btn(input bit m, input bit i, input int hold);
        btn_mode = m;
        btn_inc  = i;
        repeat (hold) @(negedge clk);
        btn_mode = 0;
        btn_inc  = 0;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] st, su, mt, mu;
        logic       emin, ehr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit found;
        int m_hold, i_hold;

        vecs[0] = '{4'd5, 4'd9, 4'd1, 4'd2, 1'b1, 1'b0};
        vecs[1] = '{4'd5, 4'd9, 4'd5, 4'd9, 1'b1, 1'b1};
        vecs[2] = '{4'd0, 4'd0, 4'd5, 4'd9, 1'b0, 1'b0};
        vecs[3] = '{4'd5, 4'd8, 4'd5, 4'd9, 1'b0, 1'b0};
        vecs[4] = '{4'd4, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0};
        vecs[5] = '{4'd5, 4'd9, 4'd5, 4'd8, 1'b1, 1'b0};
        vecs[6] = '{4'd15, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0};
        vecs[7] = '{4'd5, 4'd15, 4'd5, 4'd9, 1'b0, 1'b0};
        vecs[8] = '{4'd5, 4'd9, 4'd10, 4'd9, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset_state", {sec_en, tick_1hz, min_en, hr_en, sec_clr, mode, blink}, 0);
        #1 reset_n = 1;

        // Free-running ticks on cycles 4, 8, 12 after reset release.
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("run_sec_en", sec_en, (c % TICK_DIV) == 0);
            chk("run_tick", tick_1hz, (c % TICK_DIV) == 0);
            chk("run_no_carry", {min_en, hr_en}, 0);
            chk("run_mode", mode, 0);
        end

        foreach (vecs[v]) begin
            sec_tens = vecs[v].st; sec_units = vecs[v].su;
            min_tens = vecs[v].mt; min_units = vecs[v].mu;
            wait_tick();
            chk("vec_tick", tick_1hz, 1);
            chk("vec_min_en", min_en, vecs[v].emin);
            chk("vec_hr_en", hr_en, vecs[v].ehr);
        end
        sec_tens = 0; sec_units = 0; min_tens = 0; min_units = 0;

        // Mode press: effect on the 3rd sampling edge, exactly once while held.
        btn_mode = 1;
        @(negedge clk); chk("mode_edge1", mode, 0);
        @(negedge clk); chk("mode_edge2", mode, 0);
        @(negedge clk); chk("mode_edge3", mode, 1);
        chk("set_blink0", blink, 0);
        clr_counts();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 7) btn_mode = 0;
            chk("set_hr_hold", mode, 1);
            chk("set_blink", blink, ((k % 4) >= 2));
        end
        chk("set_no_tick", n_sec, 0);

        clr_counts();
        pulse_btn(0, 1, 3);
        pulse_btn(0, 1, 5);
        chk("inc_hr_pulses", n_hr, 2);
        chk("inc_hr_no_min", n_min, 0);
        chk("inc_hr_no_sec", n_sec, 0);

        pulse_btn(1, 0, 3);
        chk("to_set_min", mode, 2);
        clr_counts();
        pulse_btn(0, 1, 3);
        chk("inc_min_pulses", n_min, 1);
        chk("inc_min_no_hr", n_hr, 0);

        // Leaving SET_MIN: one sec_clr, then first tick exactly TICK_DIV cycles later.
        clr_counts();
        btn_mode = 1;
        found = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (sec_clr) begin
                found = 1;
                break;
            end
        end
        chk("sec_clr_seen", found, 1);
        chk("exit_mode", mode, 0);
        chk("exit_blink", blink, 0);
        for (int j = 1; j <= TICK_DIV; j++) begin
            @(negedge clk);
            if (j == 2) btn_mode = 0;
            chk("sec_clr_width", sec_clr, 0);
            chk("first_tick", sec_en, j == TICK_DIV);
        end
        chk("sec_clr_count", n_clr, 1);

        // Simultaneous mode and inc in SET_HR: mode wins.
        pulse_btn(1, 0, 3);
        chk("reenter_set_hr", mode, 1);
        clr_counts();
        pulse_btn(1, 1, 3);
        chk("both_mode", mode, 2);
        chk("both_no_hr", n_hr, 0);
        chk("both_no_min", n_min, 0);
        pulse_btn(1, 0, 3);
        chk("back_to_run", mode, 0);

        // Reset two cycles before a tick discards it and restarts the prescaler.
        wait_tick();
        repeat (2) @(negedge clk);
        #1 reset_n = 0;
        #1 chk("midreset_outputs", {sec_en, tick_1hz, min_en, hr_en, sec_clr, mode, blink}, 0);
        clr_counts();
        repeat (3) @(negedge clk);
        chk("midreset_no_tick", n_sec, 0);
        #1 reset_n = 1;
        for (int j = 1; j <= TICK_DIV; j++) begin
            @(negedge clk);
            chk("post_reset_tick", sec_en, j == TICK_DIV);
        end

        // Randomized buttons and BCD inputs, checked by the reference model.
        m_hold = 0;
        i_hold = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (m_hold == 0) begin
                btn_mode = 1'($urandom_range(0, 1));
                m_hold = $urandom_range(1, 30);
            end else begin
                m_hold--;
            end
            if (i_hold == 0) begin
                btn_inc = 1'($urandom_range(0, 1));
                i_hold = $urandom_range(1, 8);
            end else begin
                i_hold--;
            end
            sec_tens  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd5;
            sec_units = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd9;
            min_tens  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd5;
            min_units = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd9;
        end
        btn_mode = 0;
        btn_inc = 0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
